// File: rtl/cw310_reg_bank_pkg.sv
// Shared decode helpers for the CW310 USB register bank: region encoding,
// sticky/pulse address offsets and the byte-slice macro.
`define REG_BANK_BYTE(word, k) word[(k)*8 +: 8]

package cw310_reg_bank_pkg;

    typedef enum logic [2:0] {
        REGION_NONE   = 3'd0,
        REGION_CTRL   = 3'd1,
        REGION_STATUS = 3'd2,
        REGION_STICKY = 3'd3,
        REGION_PULSE  = 3'd4
    } region_e;

    // Offset of the sticky event register (REG_BANK_STICKY_OFS = 2N).
    function automatic int reg_bank_sticky_ofs(input int num_regs);
        return 2 * num_regs;
    endfunction

    // Offset of the self-clearing pulse register (REG_BANK_PULSE_OFS = 2N+1).
    function automatic int reg_bank_pulse_ofs(input int num_regs);
        return (2 * num_regs) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cw310_reg_bank_sticky.sv
// Write-1-to-clear sticky event register with a registered OR of all bits.
// A set and a clear of the same bit in one cycle leaves the bit set.
module cw310_reg_bank_sticky #(
    parameter int pWIDTH = 32
) (
    input  logic              usb_clk,
    input  logic              reset_n,
    input  logic [pWIDTH-1:0] event_set,
    input  logic [pWIDTH-1:0] clear_mask,
    output logic [pWIDTH-1:0] sticky,
    output logic              event_any
);

    logic [pWIDTH-1:0] sticky_r;
    logic              event_any_r;

    // Sticky accumulation and its one-cycle-delayed summary flag
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_r    <= '0;
            event_any_r <= 1'b0;
        end else begin
            sticky_r    <= (sticky_r & ~clear_mask) | event_set;
            event_any_r <= |sticky_r;
        end
    end

    assign sticky    = sticky_r;
    assign event_any = event_any_r;

endmodule

// File: rtl/cw310_reg_bank.sv
// CW310 USB register bank: atomic multi-byte control registers, snapshot status
// reads, sticky W1C events and pulse commands. Define REG_BANK_READ_PIPE_EN to
// register read_data (one usb_clk of read latency).
module cw310_reg_bank
    import cw310_reg_bank_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pNUM_REGS     = 8,
    parameter int pREG_BYTES    = 4,
    parameter int pBASE_ADDR    = 0,
    parameter logic [pNUM_REGS*pREG_BYTES*8-1:0] pCTRL_RESET = '0
) (
    input  logic                                   usb_clk,
    input  logic                                   reset_n,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
    input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
    input  logic                                   reg_addrvalid,
    input  logic                                   reg_read,
    input  logic                                   reg_write,
    input  logic [7:0]                             write_data,
    output logic [7:0]                             read_data,
    input  logic [pNUM_REGS*pREG_BYTES*8-1:0]      I_status,
    input  logic [pREG_BYTES*8-1:0]                I_event,
    output logic [pNUM_REGS*pREG_BYTES*8-1:0]      O_ctrl,
    output logic [pREG_BYTES*8-1:0]                O_pulse,
    output logic                                   O_event_any
);

    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int W  = pREG_BYTES * 8;
    localparam int IW = idx_width(pNUM_REGS);
    localparam int KW = idx_width(pREG_BYTES);

    localparam logic [AW-1:0]            BASE       = AW'(pBASE_ADDR);
    localparam logic [AW-1:0]            STAT_OFS   = AW'(pNUM_REGS);
    localparam logic [AW-1:0]            STICKY_OFS = AW'(reg_bank_sticky_ofs(pNUM_REGS));
    localparam logic [AW-1:0]            PULSE_OFS  = AW'(reg_bank_pulse_ofs(pNUM_REGS));
    localparam logic [pBYTECNT_SIZE-1:0] NUM_BYTES  = pBYTECNT_SIZE'(pREG_BYTES);
    localparam logic [KW-1:0]            LAST_K     = KW'(pREG_BYTES - 1);

    logic [AW-1:0] idx_s;
    region_e       region_s;
    logic [IW-1:0] ctrl_idx_s;
    logic [IW-1:0] stat_idx_s;
    logic [KW-1:0] k_s;
    logic          byte_ok_s;
    logic          wr_s;
    logic          rd_s;
    logic [W-1:0]  wr_word_s;

    logic [W-1:0]  ctrl_r [pNUM_REGS];
    logic [W-1:0]  shadow_r;
    logic [IW-1:0] shadow_idx_r;
    logic          shadow_vld_r;
    logic [W-1:0]  shadow_base_s;
    logic [W-1:0]  merged_s;
    logic          ctrl_wr_s;

    logic [W-1:0]  snap_r;
    logic [IW-1:0] snap_idx_r;
    logic          snap_vld_r;
    logic [W-1:0]  live_stat_s;
    logic          stat_rd0_s;

    logic [W-1:0]  sticky_s;
    logic [W-1:0]  clear_mask_s;
    logic [W-1:0]  pulse_r;
    logic [7:0]    rd_byte_s;

    // Address and byte-index decode shared by the read and write paths
    always_comb begin
        idx_s    = reg_address - BASE;
        region_s = REGION_NONE;
        if (reg_address < BASE) begin
            region_s = REGION_NONE;
        end else if (idx_s < STAT_OFS) begin
            region_s = REGION_CTRL;
        end else if (idx_s < STICKY_OFS) begin
            region_s = REGION_STATUS;
        end else if (idx_s == STICKY_OFS) begin
            region_s = REGION_STICKY;
        end else if (idx_s == PULSE_OFS) begin
            region_s = REGION_PULSE;
        end else begin
            region_s = REGION_NONE;
        end
    end

    assign ctrl_idx_s = idx_s[IW-1:0];
    assign stat_idx_s = IW'(idx_s - STAT_OFS);
    assign k_s        = reg_bytecnt[KW-1:0];
    assign byte_ok_s  = (reg_bytecnt < NUM_BYTES);
    assign wr_s       = reg_addrvalid && reg_write && byte_ok_s;
    assign rd_s       = reg_addrvalid && reg_read;
    assign wr_word_s  = W'(write_data) << (k_s * 8);

    // Byte merge: restart from the committed word on byte 0 or a change of register
    always_comb begin
        if ((k_s == '0) || !shadow_vld_r || (shadow_idx_r != ctrl_idx_s)) begin
            shadow_base_s = ctrl_r[ctrl_idx_s];
        end else begin
            shadow_base_s = shadow_r;
        end
        merged_s = shadow_base_s;
        `REG_BANK_BYTE(merged_s, k_s) = write_data;
    end

    assign ctrl_wr_s = wr_s && (region_s == REGION_CTRL);

    // Control registers commit only on the last byte; earlier bytes stay in the shadow
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < pNUM_REGS; i++) begin
                ctrl_r[i] <= pCTRL_RESET[i*W +: W];
            end
            shadow_r     <= '0;
            shadow_idx_r <= '0;
            shadow_vld_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            if (k_s == LAST_K) begin
                ctrl_r[ctrl_idx_s] <= merged_s;
                shadow_vld_r       <= 1'b0;
            end else begin
                shadow_r     <= merged_s;
                shadow_idx_r <= ctrl_idx_s;
                shadow_vld_r <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < pNUM_REGS; g++) begin : g_ctrl_out
        assign O_ctrl[g*W +: W] = ctrl_r[g];
    end

    assign live_stat_s = I_status[stat_idx_s*W +: W];
    assign stat_rd0_s  = rd_s && (region_s == REGION_STATUS) && (reg_bytecnt == '0);

    // Status snapshot, captured whole on a byte-0 read so later bytes are coherent
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_r     <= '0;
            snap_idx_r <= '0;
            snap_vld_r <= 1'b0;
        end else if (stat_rd0_s) begin
            snap_r     <= live_stat_s;
            snap_idx_r <= stat_idx_s;
            snap_vld_r <= 1'b1;
        end
    end

    assign clear_mask_s = (wr_s && (region_s == REGION_STICKY)) ? wr_word_s : '0;

    cw310_reg_bank_sticky #(
        .pWIDTH (W)
    ) u_sticky (
        .usb_clk    (usb_clk),
        .reset_n    (reset_n),
        .event_set  (I_event),
        .clear_mask (clear_mask_s),
        .sticky     (sticky_s),
        .event_any  (O_event_any)
    );

    // Command pulses last exactly one cycle after the write edge
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_r <= '0;
        end else if (wr_s && (region_s == REGION_PULSE)) begin
            pulse_r <= wr_word_s;
        end else begin
            pulse_r <= '0;
        end
    end

    assign O_pulse = pulse_r;

    // Read mux; control reads always show the committed word, never the shadow
    always_comb begin
        rd_byte_s = 8'h00;
        if (rd_s && byte_ok_s) begin
            case (region_s)
                REGION_CTRL:   rd_byte_s = `REG_BANK_BYTE(ctrl_r[ctrl_idx_s], k_s);
                REGION_STATUS: begin
                    if ((reg_bytecnt != '0) && snap_vld_r && (snap_idx_r == stat_idx_s)) begin
                        rd_byte_s = `REG_BANK_BYTE(snap_r, k_s);
                    end else begin
                        rd_byte_s = `REG_BANK_BYTE(live_stat_s, k_s);
                    end
                end
                REGION_STICKY: rd_byte_s = `REG_BANK_BYTE(sticky_s, k_s);
                REGION_PULSE:  rd_byte_s = 8'h00;
                default:       rd_byte_s = 8'h00;
            endcase
        end else begin
            rd_byte_s = 8'h00;
        end
    end

`ifdef REG_BANK_READ_PIPE_EN
    logic [7:0] read_data_r;

    // Registered read path
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_r <= 8'h00;
        end else begin
            read_data_r <= rd_byte_s;
        end
    end

    assign read_data = read_data_r;
`else
    assign read_data = rd_byte_s;
`endif

endmodule

// File: tb/tb_cw310_reg_bank.sv
// Self-checking bench for cw310_reg_bank (8 regs x 4 bytes, distinct control reset values).
module tb_cw310_reg_bank;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int AW = 14;
    localparam int BC = 7;
    localparam logic [N*W-1:0] CTRL_RST =
        256'hC7B7A797_C6B6A696_C5B5A595_C4B4A494_C3B3A393_C2B2A292_C1B1A191_C0B0A090;

    localparam logic [1:0] OP_WR = 2'd0;
    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_CK = 2'd2;

    logic            usb_clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW-1:0]   reg_address = '0;
    logic [BC-1:0]   reg_bytecnt = '0;
    logic            reg_addrvalid = 1'b0;
    logic            reg_read = 1'b0;
    logic            reg_write = 1'b0;
    logic [7:0]      write_data = 8'h00;
    logic [7:0]      read_data;
    logic [N*W-1:0]  I_status = '0;
    logic [W-1:0]    I_event = '0;
    logic [N*W-1:0]  O_ctrl;
    logic [W-1:0]    O_pulse;
    logic            O_event_any;

    int n_checks = 0;
    int n_fail   = 0;

    cw310_reg_bank #(
        .pADDR_WIDTH   (21),
        .pBYTECNT_SIZE (7),
        .pNUM_REGS     (N),
        .pREG_BYTES    (4),
        .pBASE_ADDR    (0),
        .pCTRL_RESET   (CTRL_RST)
    ) dut (
        .usb_clk       (usb_clk),
        .reset_n       (reset_n),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_addrvalid (reg_addrvalid),
        .reg_read      (reg_read),
        .reg_write     (reg_write),
        .write_data    (write_data),
        .read_data     (read_data),
        .I_status      (I_status),
        .I_event       (I_event),
        .O_ctrl        (O_ctrl),
        .O_pulse       (O_pulse),
        .O_event_any   (O_event_any)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [BC-1:0] k;
        logic [7:0]    wd;
        int            chk;
        logic [31:0]   exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_rst(input int i);
        return 32'hC0B0A090 + (32'h01010101 * i);
    endfunction

    function automatic logic [N*W-1:0] rst_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = ctrl_rst(i);
        return v;
    endfunction

    function automatic logic [31:0] ctrl_word(input int i);
        return O_ctrl[i*W +: W];
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [BC-1:0] k, input logic [7:0] d);
        @(negedge usb_clk);
        reg_address = a; reg_bytecnt = k; write_data = d;
        reg_addrvalid = 1'b1; reg_write = 1'b1;
        @(posedge usb_clk); #1;
        reg_addrvalid = 1'b0; reg_write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [BC-1:0] k, output logic [7:0] d);
        @(negedge usb_clk);
        reg_address = a; reg_bytecnt = k;
        reg_addrvalid = 1'b1; reg_read = 1'b1;
`ifdef REG_BANK_READ_PIPE_EN
        @(posedge usb_clk); #1;
        d = read_data;
`else
        #1;
        d = read_data;
        @(posedge usb_clk); #1;
`endif
        reg_addrvalid = 1'b0; reg_read = 1'b0;
    endtask

    initial begin
        logic [7:0]     d;
        logic [N*W-1:0] exp_full;

        vecs.push_back('{OP_WR, 14'd2, 7'd0, 8'h11, 2, 32'hC2B2A292});
        vecs.push_back('{OP_WR, 14'd2, 7'd1, 8'h22, 2, 32'hC2B2A292});
        vecs.push_back('{OP_WR, 14'd2, 7'd2, 8'h33, 2, 32'hC2B2A292});
        vecs.push_back('{OP_WR, 14'd2, 7'd3, 8'h44, 2, 32'h44332211});
        vecs.push_back('{OP_CK, 14'd0, 7'd0, 8'h00, 3, 32'hC3B3A393});
        vecs.push_back('{OP_CK, 14'd0, 7'd0, 8'h00, 1, 32'hC1B1A191});
        vecs.push_back('{OP_WR, 14'd1, 7'd0, 8'h55, 1, 32'hC1B1A191});
        vecs.push_back('{OP_WR, 14'd1, 7'd1, 8'h66, 1, 32'hC1B1A191});
        vecs.push_back('{OP_WR, 14'd1, 7'd3, 8'h77, 1, 32'h77B16655});
        vecs.push_back('{OP_CK, 14'd0, 7'd0, 8'h00, 2, 32'h44332211});
        vecs.push_back('{OP_RD, 14'd1, 7'd0, 8'h00, 0, 32'h00000055});
        vecs.push_back('{OP_RD, 14'd1, 7'd2, 8'h00, 0, 32'h000000B1});
        vecs.push_back('{OP_RD, 14'd1, 7'd3, 8'h00, 0, 32'h00000077});
        vecs.push_back('{OP_RD, 14'd2, 7'd1, 8'h00, 0, 32'h00000022});
        vecs.push_back('{OP_RD, 14'd0, 7'd0, 8'h00, 0, 32'h00000090});
        vecs.push_back('{OP_RD, 14'd1, 7'd4, 8'h00, 0, 32'h00000000});
        vecs.push_back('{OP_WR, 14'd1, 7'd5, 8'hFF, 1, 32'h77B16655});
        vecs.push_back('{OP_WR, 14'd1, 7'd0, 8'hAA, 1, 32'h77B16655});
        vecs.push_back('{OP_RD, 14'd1, 7'd0, 8'h00, 0, 32'h00000055});
        vecs.push_back('{OP_WR, 14'd4, 7'd1, 8'h99, 4, 32'hC4B4A494});
        vecs.push_back('{OP_WR, 14'd4, 7'd3, 8'h98, 4, 32'h98B49994});
        vecs.push_back('{OP_CK, 14'd0, 7'd0, 8'h00, 1, 32'h77B16655});
        vecs.push_back('{OP_RD, 14'd18, 7'd0, 8'h00, 0, 32'h00000000});
        vecs.push_back('{OP_RD, 14'd17, 7'd1, 8'h00, 0, 32'h00000000});

        // Reset state
        #12;
        check("rst_ctrl", O_ctrl, rst_vec());
        check("rst_pulse", O_pulse, 256'h0);
        check("rst_event_any", O_event_any, 256'h0);
        check("rst_read_data", read_data, 256'h0);
        @(negedge usb_clk);
        reset_n = 1'b1;

        // Control write/read table
        foreach (vecs[i]) begin
            if (vecs[i].op == OP_WR) begin
                wr(vecs[i].addr, vecs[i].k, vecs[i].wd);
                check($sformatf("vec%0d_ctrl%0d", i, vecs[i].chk), ctrl_word(vecs[i].chk), vecs[i].exp);
            end else if (vecs[i].op == OP_RD) begin
                rd(vecs[i].addr, vecs[i].k, d);
                check($sformatf("vec%0d_rd", i), d, vecs[i].exp);
            end else begin
                check($sformatf("vec%0d_ctrl%0d", i, vecs[i].chk), ctrl_word(vecs[i].chk), vecs[i].exp);
            end
        end

        // Coherent status snapshot
        I_status[31:0]  = 32'h000000FF;
        I_status[63:32] = 32'h12345678;
        rd(14'd8, 7'd0, d);  check("stat_b0", d, 256'hFF);
        I_status[31:0]  = 32'hAABBCC00;
        rd(14'd8, 7'd1, d);  check("stat_b1_snap", d, 256'h00);
        rd(14'd8, 7'd2, d);  check("stat_b2_snap", d, 256'h00);
        rd(14'd8, 7'd3, d);  check("stat_b3_snap", d, 256'h00);
        rd(14'd9, 7'd1, d);  check("stat1_b1_live", d, 256'h56);
        rd(14'd8, 7'd0, d);  check("stat_b0_live", d, 256'h00);
        rd(14'd8, 7'd3, d);  check("stat_b3_new_snap", d, 256'hAA);
        repeat (2) @(posedge usb_clk);
        #1;
        check("idle_read_zero", read_data, 256'h0);

        // Sticky set, set-wins-over-clear, W1C and event_any lag
        @(negedge usb_clk);
        I_event = 32'h00000120;
        @(posedge usb_clk); #1;
        I_event = '0;
        check("event_any_lag", O_event_any, 256'h0);
        @(posedge usb_clk); #1;
        check("event_any_set", O_event_any, 256'h1);
        @(negedge usb_clk);
        I_event = 32'h00000020;
        reg_address = 14'd16; reg_bytecnt = 7'd0; write_data = 8'h20;
        reg_addrvalid = 1'b1; reg_write = 1'b1;
        @(posedge usb_clk); #1;
        reg_addrvalid = 1'b0; reg_write = 1'b0; I_event = '0;
        rd(14'd16, 7'd0, d); check("sticky_set_wins", d, 256'h20);
        wr(14'd16, 7'd0, 8'h20);
        rd(14'd16, 7'd0, d); check("sticky_b0_clr", d, 256'h00);
        rd(14'd16, 7'd1, d); check("sticky_b1_kept", d, 256'h01);
        check("event_any_still", O_event_any, 256'h1);
        wr(14'd16, 7'd1, 8'h01);
        check("event_any_lag_fall", O_event_any, 256'h1);
        @(posedge usb_clk); #1;
        check("event_any_fall", O_event_any, 256'h0);

        // Pulse register and out-of-range write
        wr(14'd17, 7'd1, 8'h81);
        check("pulse_hi", O_pulse, 256'h00008100);
        @(posedge usb_clk); #1;
        check("pulse_lo", O_pulse, 256'h0);
        wr(14'd18, 7'd0, 8'hFF);
        exp_full = rst_vec();
        exp_full[32 +: 32]  = 32'h77B16655;
        exp_full[64 +: 32]  = 32'h44332211;
        exp_full[128 +: 32] = 32'h98B49994;
        check("oob_ctrl", O_ctrl, exp_full);
        check("oob_pulse", O_pulse, 256'h0);
        rd(14'd16, 7'd0, d); check("oob_sticky", d, 256'h00);

        // Reset in the middle of a partial write
        wr(14'd3, 7'd0, 8'hEE);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", O_ctrl, rst_vec());
        check("midrst_pulse", O_pulse, 256'h0);
        @(negedge usb_clk);
        reset_n = 1'b1;
        wr(14'd3, 7'd3, 8'h12);
        check("post_rst_commit", ctrl_word(3), 256'h12B3A393);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
